// File: rtl/ntt_pkg.sv
// Shared constants and FSM state encoding for the BRAM read streamer.
package ntt_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;

endpackage

// File: rtl/bram_rd_streamer_if.sv
// Downstream valid/ready word stream leaving the BRAM read streamer.
interface bram_rd_streamer_if
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/stream_skid2.sv
// Two-entry in-order word buffer; slot0 is always the head presented downstream.
module stream_skid2
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic [1:0]        cnt;

  // Slot/occupancy update; the head only changes on pop or a push into an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            slot0 <= push_data;
            cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= push_data;
          end else if (push) begin
            slot1 <= push_data;
            cnt   <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        2'd2: begin
          // A push without a pop here is prevented by the issuer's credit check.
          if (pop) begin
            slot0 <= slot1;
            if (push) begin
              slot1 <= push_data;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  assign head = slot0;
  assign occ  = cnt;

endmodule

// File: rtl/bram_rd_streamer.sv
// Streams a burst of consecutive BRAM words onto a valid/ready interface.
// Optional feature macro: BRAM_RD_STREAMER_BITREV_EN adds a bitrev input that
// selects bit-reversed (XOR base) address order for the burst.
module bram_rd_streamer
  import ntt_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
`ifdef BRAM_RD_STREAMER_BITREV_EN
  input  logic              bitrev,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_dout,
  bram_rd_streamer_if.master out,
  output logic              busy,
  output logic              done
);

  stream_state_t     state;
  stream_state_t     state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic              valid;
  logic [1:0]        occ;
  logic [2:0]        load;
  logic [DATA_W-1:0] head;

`ifdef BRAM_RD_STREAMER_BITREV_EN
  logic bitrev_q;

  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      r[i] = v[int'(ADDR_W) - 1 - i];
    end
    return r;
  endfunction
`endif

  assign valid = (occ != 2'd0);
  assign pop   = valid & out.out_ready;
  // Words held or owed to the buffer once this cycle's pop leaves.
  assign load  = 3'(occ) + 3'(inflight) - 3'(pop);
  assign busy  = (state != ST_IDLE);

  assign out.out_valid = valid;
  assign out.out_data  = head;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read-issue decision and end-of-burst pulse.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = (load <= 3'd1);
        if (issue && (cnt == len_q)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (load == 3'd0) begin
          state_nxt = ST_IDLE;
          done      = pop & ~rst;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst parameters, issue counter, in-flight flag and last issued address.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      last_addr <= '0;
`ifdef BRAM_RD_STREAMER_BITREV_EN
      bitrev_q  <= 1'b0;
`endif
    end else begin
      inflight <= issue;
      if ((state == ST_IDLE) && start) begin
        base_q   <= base_addr;
        len_q    <= len_m1;
        cnt      <= '0;
`ifdef BRAM_RD_STREAMER_BITREV_EN
        bitrev_q <= bitrev;
`endif
      end else if (issue) begin
        cnt <= cnt + ADDR_W'(1);
      end
      if (issue) begin
        last_addr <= issue_addr;
      end
    end
  end

  // Read address: current issue address, otherwise hold the last one issued.
  always_comb begin
    issue_addr = base_q + cnt;
`ifdef BRAM_RD_STREAMER_BITREV_EN
    if (bitrev_q) begin
      issue_addr = base_q ^ bit_reverse(cnt);
    end
`endif
    rd_addr = issue ? issue_addr : last_addr;
  end

  stream_skid2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(rd_dout),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Scoreboard bench for bram_rd_streamer with a registered-read BRAM model (BRAM[i] = i).
module tb_bram_rd_streamer;
  import ntt_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 18;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len_m1 = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dout = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem [0:(1<<AW)-1];
`ifdef BRAM_RD_STREAMER_BITREV_EN
  logic          bitrev = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  bram_rd_streamer_if #(.DATA_W(DW)) sif ();

  bram_rd_streamer #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len_m1   (len_m1),
`ifdef BRAM_RD_STREAMER_BITREV_EN
    .bitrev   (bitrev),
`endif
    .rd_addr  (rd_addr),
    .rd_dout  (rd_dout),
    .out      (sif),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // BRAM model: address registered, data one cycle later.
  always @(posedge clk) rd_dout <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic expect_range(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      expect_word(DW'((b + i) % (1 << AW)), (i == n - 1));
    end
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start     = 1'b1;
    base_addr = b;
    len_m1    = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (sif.out_valid && sif.out_ready) begin
        accepted++;
        if (done) done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(sif.out_data), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(sif.out_data), 32'(e.data));
          check("done_on_word", 32'(done), 32'(e.last));
        end
      end else begin
        check("done_no_handshake", 32'(done), 32'd0);
        if (sif.out_valid && exp_q.size() != 0) begin
          check("stall_hold_data", 32'(sif.out_data), 32'(exp_q[0].data));
        end
      end
    end
  end

  initial begin
    int acc0;
    int dc0;
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    sif.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_data", 32'(sif.out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Burst 0x010..0x013 with ready held high: latency and throughput
    sif.out_ready = 1'b1;
    expect_word(18'h00010, 1'b0);
    expect_word(18'h00011, 1'b0);
    expect_word(18'h00012, 1'b0);
    expect_word(18'h00013, 1'b1);
    start_burst(9'h010, 9'd3);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(sif.out_valid), 32'd0);
    tick();
    check("t1_valid_e1", 32'(sif.out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t1_valid_stream", 32'(sif.out_valid), 32'd1);
    end
    tick();
    check("t1_valid_end", 32'(sif.out_valid), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Back-to-back burst with address wrap past 0x1FF
    expect_word(18'h001FE, 1'b0);
    expect_word(18'h001FF, 1'b0);
    expect_word(18'h00000, 1'b0);
    expect_word(18'h00001, 1'b1);
    start_burst(9'h1FE, 9'd3);
    check("t2_rd_addr0", 32'(rd_addr), 32'h1FE);
    tick();
    check("t2_rd_addr1", 32'(rd_addr), 32'h1FF);
    tick();
    check("t2_rd_addr2", 32'(rd_addr), 32'h000);
    tick();
    check("t2_rd_addr3", 32'(rd_addr), 32'h001);
    wait_drain("t2", 50);

    // 16 words under random backpressure
    expect_range(32'h0A0, 16);
    start_burst(9'h0A0, 9'd15);
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      sif.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("t3_drain_in_time", 32'(n < 500), 32'd1);
    sif.out_ready = 1'b1;
    tick();

    // Reset in the middle of a burst, then a clean burst
    expect_range(32'h040, 16);
    acc0 = accepted;
    start_burst(9'h040, 9'd15);
    n = 0;
    while ((accepted - acc0) < 5 && n < 50) begin
      tick();
      n++;
    end
    check("t4_reach_word5", 32'(n < 50), 32'd1);
    rst = 1'b1;
    sif.out_ready = 1'b0;
    exp_q.delete();
    tick();
    check("t4_rst_valid", 32'(sif.out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    sif.out_ready = 1'b1;
    tick();
    expect_range(32'h100, 6);
    start_burst(9'h100, 9'd5);
    wait_drain("t4_clean", 50);

    // Full-depth burst with a start pulse while busy
    dc0 = done_cnt;
    expect_range(32'h123, 512);
    start_burst(9'h123, 9'h1FF);
    for (int c = 0; c < 10; c++) tick();
    start     = 1'b1;
    base_addr = 9'h000;
    len_m1    = 9'd3;
    tick();
    start = 1'b0;
    wait_drain("t5", 2000);
    check("t5_done_pulses", 32'(done_cnt - dc0), 32'd1);

`ifdef BRAM_RD_STREAMER_BITREV_EN
    // Bit-reversed order, base 0: bitreverse9(k) for k=0..7
    bitrev = 1'b1;
    expect_word(18'h000, 1'b0);
    expect_word(18'h100, 1'b0);
    expect_word(18'h080, 1'b0);
    expect_word(18'h180, 1'b0);
    expect_word(18'h040, 1'b0);
    expect_word(18'h140, 1'b0);
    expect_word(18'h0C0, 1'b0);
    expect_word(18'h1C0, 1'b1);
    start_burst(9'h000, 9'd7);
    bitrev = 1'b0;
    wait_drain("bitrev", 100);
`endif

    tick();
    check("end_idle_busy", 32'(busy), 32'd0);
    check("end_idle_valid", 32'(sif.out_valid), 32'd0);
`ifdef BRAM_RD_STREAMER_BITREV_EN
    check("end_done_total", 32'(done_cnt), 32'd6);
`else
    check("end_done_total", 32'(done_cnt), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
